// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 4-bit accumulator CPU: reads opcode/operand nibble
// pairs from program memory, resolves jumps locally and issues only ALU instructions.
module fetch_unit #(
  parameter logic [3:0] RESET_PC          = 4'h0,
  parameter bit         HALT_ON_SELF_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       mem_req,
  output logic [3:0] mem_addr,
  input  logic       mem_rvalid,
  input  logic [3:0] mem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] instr_opcode,
  output logic [3:0] instr_operand,
  output logic [3:0] instr_pc,
  output logic       halted,
  output logic [7:0] issue_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OP_REQ  = 3'd1,
    ARG_REQ = 3'd2,
    ISSUE   = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic       mem_req_q, mem_req_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic       instr_valid_q, instr_valid_d;
  logic [3:0] instr_opcode_q, instr_opcode_d;
  logic [3:0] instr_operand_q, instr_operand_d;
  logic [3:0] instr_pc_q, instr_pc_d;
  logic       halted_q, halted_d;
  logic [7:0] issue_count_q, issue_count_d;

  logic       rd_fire;
  logic [3:0] jump_target;

  // Responses only count while a request is outstanding; stray valids are dropped.
  assign rd_fire     = mem_req_q && mem_rvalid;
  assign jump_target = instr_opcode_q[2] ? (pc_q + mem_rdata) : mem_rdata;

  // Next-state, PC and instruction-register update.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_opcode_d  = instr_opcode_q;
    instr_operand_d = instr_operand_q;
    instr_pc_d      = instr_pc_q;
    issue_count_d   = issue_count_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = OP_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      OP_REQ: begin
        if (rd_fire) begin
          instr_opcode_d = mem_rdata;
          instr_pc_d     = pc_q;
          state_d        = ARG_REQ;
        end else begin
          state_d = OP_REQ;
        end
      end
      ARG_REQ: begin
        if (rd_fire) begin
          instr_operand_d = mem_rdata;
          if (!instr_opcode_q[3]) begin
            state_d = ISSUE;
          end else if (HALT_ON_SELF_JUMP && (jump_target == pc_q)) begin
            state_d = HALT;
          end else begin
            pc_d    = jump_target;
            state_d = IDLE;
          end
        end else begin
          state_d = ARG_REQ;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          pc_d          = pc_q + 4'd2;
          issue_count_d = issue_count_q + 8'd1;
          state_d       = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Port outputs are registered copies of what the next state presents.
    mem_req_d     = (state_d == OP_REQ) || (state_d == ARG_REQ);
    mem_addr_d    = (state_d == ARG_REQ) ? (pc_d + 4'd1) : pc_d;
    instr_valid_d = (state_d == ISSUE);
    halted_d      = (state_d == HALT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= RESET_PC;
      instr_valid_q   <= 1'b0;
      instr_opcode_q  <= 4'h0;
      instr_operand_q <= 4'h0;
      instr_pc_q      <= 4'h0;
      halted_q        <= 1'b0;
      issue_count_q   <= 8'h00;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      instr_valid_q   <= instr_valid_d;
      instr_opcode_q  <= instr_opcode_d;
      instr_operand_q <= instr_operand_d;
      instr_pc_q      <= instr_pc_d;
      halted_q        <= halted_d;
      issue_count_q   <= issue_count_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign instr_valid   = instr_valid_q;
  assign instr_opcode  = instr_opcode_q;
  assign instr_operand = instr_operand_q;
  assign instr_pc      = instr_pc_q;
  assign halted        = halted_q;
  assign issue_count   = issue_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an instruction-level program walk predicts the
// read-address sequence, issued instructions, issue count and halt point.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       mem_rvalid = 1'b0;
  logic [3:0] mem_rdata = 4'h0;
  logic       instr_ready = 1'b0;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       instr_valid;
  logic [3:0] instr_opcode;
  logic [3:0] instr_operand;
  logic [3:0] instr_pc;
  logic       halted;
  logic [7:0] issue_count;

  fetch_unit dut (
    .clk(clk), .reset(reset), .en(en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .instr_pc(instr_pc), .halted(halted), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] mem [16];
  int         lat = 1;
  bit         spur = 1'b0;
  bit         rnd_ready = 1'b0;
  int         mcnt = 0;

  logic [3:0]  exp_reads[$];
  logic [11:0] exp_issues[$];
  bit          trace_halts = 1'b0;
  bit          m_halted = 1'b0;
  logic [7:0]  m_count = 8'h00;
  bit          live = 1'b0;
  bit          prev_reset = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Walk the program at instruction level from the reset PC.
  task automatic build_trace();
    logic [3:0] pc, pc1, op, arg, tgt;
    exp_reads.delete();
    exp_issues.delete();
    trace_halts = 1'b0;
    pc = 4'h0;
    for (int i = 0; i < 160; i++) begin
      pc1 = pc + 4'd1;
      op  = mem[pc];
      arg = mem[pc1];
      exp_reads.push_back(pc);
      exp_reads.push_back(pc1);
      if (!op[3]) begin
        exp_issues.push_back({op, arg, pc});
        pc = pc + 4'd2;
      end else begin
        tgt = op[2] ? (pc + arg) : arg;
        if (tgt == pc) begin
          trace_halts = 1'b1;
          break;
        end
        pc = tgt;
      end
    end
  endtask

  // Compare process: every negedge, check outputs against the model, then advance it.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_reset) begin
          chk("rst_mem_req", 32'(mem_req), 32'd0);
          chk("rst_mem_addr", 32'(mem_addr), 32'd0);
          chk("rst_instr_valid", 32'(instr_valid), 32'd0);
          chk("rst_instr_fields", 32'({instr_opcode, instr_operand, instr_pc}), 32'd0);
          build_trace();
          m_count  = 8'h00;
          m_halted = 1'b0;
          live     = 1'b1;
        end
        if (live) begin
          chk("issue_count", 32'(issue_count), 32'(m_count));
          chk("halted", 32'(halted), 32'(m_halted));
          if (m_halted) begin
            chk("halt_mem_req", 32'(mem_req), 32'd0);
            chk("halt_instr_valid", 32'(instr_valid), 32'd0);
          end
          if (prev_valid && !prev_ready && !prev_reset)
            chk("valid_held", 32'(instr_valid), 32'd1);
          if (mem_req) begin
            if (exp_reads.size() == 0) begin
              fail_now("read_beyond_trace");
            end else begin
              chk("mem_addr", 32'(mem_addr), 32'(exp_reads[0]));
              if (mem_rvalid) begin
                void'(exp_reads.pop_front());
                if (exp_reads.size() == 0 && trace_halts) m_halted = 1'b1;
              end
            end
          end
          if (instr_valid) begin
            if (exp_issues.size() == 0) begin
              fail_now("issue_beyond_trace");
            end else begin
              chk("instr_fields", 32'({instr_opcode, instr_operand, instr_pc}), 32'(exp_issues[0]));
              if (instr_ready) begin
                void'(exp_issues.pop_front());
                m_count = m_count + 8'd1;
              end
            end
          end
        end
      end
      prev_reset = reset;
      prev_valid = instr_valid;
      prev_ready = instr_ready;
    end
  end

  // Program memory responder with configurable latency and optional stray valids.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mcnt++;
        if (mcnt >= lat) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[mem_addr];
          mcnt       = 0;
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = 4'($urandom);
        end
      end else begin
        mcnt       = 0;
        mem_rvalid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata  = 4'($urandom);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_prog(input int kind);
    for (int a = 0; a < 16; a++) mem[4'(a)] = (kind == 0) ? 4'($urandom) : 4'h0;
    if (kind == 1) begin
      mem[0] = 4'h0; mem[1] = 4'h1; mem[2] = 4'h8; mem[3] = 4'h6;
      mem[4] = 4'h8; mem[5] = 4'h4; mem[6] = 4'hC; mem[7] = 4'h3;
      mem[9] = 4'h0; mem[10] = 4'h5; mem[11] = 4'h8; mem[12] = 4'h4;
    end else if (kind == 2) begin
      mem[0] = 4'h8; mem[1] = 4'hE; mem[2] = 4'h1; mem[3] = 4'h7;
      mem[4] = 4'h8; mem[5] = 4'h4; mem[14] = 4'hC; mem[15] = 4'h3;
    end
  endtask

  task automatic reset_load(input int kind);
    step();
    reset = 1'b1;
    en    = 1'b0;
    load_prog(kind);
    step();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int bound, input string name);
    int k = 0;
    @(negedge clk);
    while (!halted && k < bound) begin
      step();
      @(negedge clk);
      k++;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  task automatic wait_req_addr(input int bound, input logic [3:0] exp, input string name);
    int k = 0;
    @(negedge clk);
    while (!mem_req && k < bound) begin
      step();
      @(negedge clk);
      k++;
    end
    chk({name, "_req"}, 32'(mem_req), 32'd1);
    chk(name, 32'(mem_addr), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  found;

    // Basic issue timing, backpressure, jumps and self-jump halt.
    lat = 1; spur = 1'b0; rnd_ready = 1'b0; instr_ready = 1'b0;
    reset_load(1);
    @(negedge clk);
    chk("a_reset_addr", 32'(mem_addr), 32'd0);
    step(); en = 1'b1;
    step(); step();
    @(negedge clk);
    chk("a_valid_early", 32'(instr_valid), 32'd0);
    step();
    @(negedge clk);
    chk("a_first_valid", 32'(instr_valid), 32'd1);
    chk("a_first_opcode", 32'(instr_opcode), 32'd0);
    chk("a_first_operand", 32'(instr_operand), 32'd1);
    chk("a_first_pc", 32'(instr_pc), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("a_bp_valid", 32'(instr_valid), 32'd1);
      chk("a_bp_operand", 32'(instr_operand), 32'd1);
      chk("a_bp_mem_req", 32'(mem_req), 32'd0);
      chk("a_bp_count", 32'(issue_count), 32'd0);
    end
    step(); instr_ready = 1'b1;
    step();
    @(negedge clk);
    chk("a_accept_valid", 32'(instr_valid), 32'd0);
    chk("a_accept_count", 32'(issue_count), 32'd1);
    step();
    @(negedge clk);
    chk("a_next_req", 32'(mem_req), 32'd1);
    chk("a_next_addr", 32'(mem_addr), 32'd2);
    wait_halt(300, "a_halted");
    chk("a_halt_count", 32'(issue_count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk("a_halt_quiet", 32'(mem_req), 32'd0);
    end
    reset_load(1);
    @(negedge clk);
    chk("a_unhalt", 32'(halted), 32'd0);
    chk("a_unhalt_pc", 32'(mem_addr), 32'd0);

    // Reset arriving together with a read response in the operand phase.
    instr_ready = 1'b1;
    reset_load(1);
    step(); en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    @(negedge clk);
    chk("d_pre_req", 32'(mem_req), 32'd1);
    chk("d_pre_rvalid", 32'(mem_rvalid), 32'd1);
    chk("d_pre_addr", 32'(mem_addr), 32'd3);
    chk("d_pre_count", 32'(issue_count), 32'd1);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("d_post_req", 32'(mem_req), 32'd0);
    chk("d_post_valid", 32'(instr_valid), 32'd0);
    chk("d_post_count", 32'(issue_count), 32'd0);
    wait_req_addr(20, 4'h0, "d_first_fetch");

    // Relative jump wrapping past address 15.
    reset_load(2);
    step(); en = 1'b1;
    k = 0; found = 1'b0;
    while (k < 100 && !found) begin
      @(negedge clk);
      if (mem_req && mem_rvalid && mem_addr == 4'hF) found = 1'b1;
      else begin
        step();
        k++;
      end
    end
    chk("c_found_15", 32'(found), 32'd1);
    wait_req_addr(20, 4'h1, "c_wrap_addr");
    wait_halt(200, "c_halted");
    chk("c_count", 32'(issue_count), 32'd1);

    // Three-cycle memory latency, stray valids and random backpressure.
    lat = 3; spur = 1'b1; rnd_ready = 1'b1;
    reset_load(1);
    step(); en = 1'b1;
    wait_halt(600, "b_halted");
    chk("b_count", 32'(issue_count), 32'd2);

    // Random programs, latencies, enable and ready patterns, occasional resets.
    for (int it = 0; it < 8; it++) begin
      lat  = int'($urandom_range(1, 4));
      spur = 1'($urandom_range(0, 1));
      reset_load(0);
      for (int c = 0; c < 250; c++) begin
        step();
        en    = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 149) == 0);
      end
      step(); reset = 1'b0;
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
